// File: rtl/mbist_pkg.sv
// rtl/mbist_pkg.sv - shared types and March C- element table for the MBIST engine
package mbist_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_e;

  localparam int NUM_ELEM = 6;

  // One bit per element index; bits 6..7 pad the table to the 3-bit element counter.
  localparam logic [7:0] ELEM_DOWN    = 8'b0001_1000;  // elements 3,4 walk addresses downward
  localparam logic [7:0] ELEM_TWO_OPS = 8'b0001_1110;  // elements 1..4 do read-then-write
  localparam logic [7:0] OP0_READ     = 8'b0011_1110;  // first op is a read except in element 0
  localparam logic [7:0] OP0_DATA     = 8'b0001_0100;  // background of the first op
  localparam logic [7:0] OP1_DATA     = 8'b0000_1010;  // background of the second op (always a write)

  // Second op of an element is always a write.
  function automatic logic op_is_read(input logic [2:0] elem, input logic op);
    return op ? 1'b0 : OP0_READ[elem];
  endfunction

  function automatic logic op_data(input logic [2:0] elem, input logic op);
    return op ? OP1_DATA[elem] : OP0_DATA[elem];
  endfunction

endpackage

// File: rtl/mbist_cmp_pipe.sv
// rtl/mbist_cmp_pipe.sv - read-tag delay line, registered comparator, saturating fail counter
module mbist_cmp_pipe #(
  parameter int WLENGTH = 4,
  parameter int AW      = 8,
  parameter int RD_LAT  = 1,
  parameter int FCW     = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clear,
  input  logic               issue_read,
  input  logic [AW-1:0]      issue_addr,
  input  logic [2:0]         issue_elem,
  input  logic [WLENGTH-1:0] issue_exp,
  input  logic [WLENGTH-1:0] mem_rdata,
  output logic               fail_valid,
  output logic [AW-1:0]      fail_addr,
  output logic [2:0]         fail_elem,
  output logic [FCW-1:0]     fail_count
);

  localparam int TW = 1 + 3 + AW + WLENGTH;

  logic [TW-1:0]      tag_q [RD_LAT];
  logic               t_read;
  logic [2:0]         t_elem;
  logic [AW-1:0]      t_addr;
  logic [WLENGTH-1:0] t_exp;
  logic               mismatch;

  // Carry each issued op's tag alongside the RAM latency so it meets its read data.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < RD_LAT; i++) tag_q[i] <= '0;
    end else begin
      tag_q[0] <= {issue_read, issue_elem, issue_addr, issue_exp};
      for (int i = 1; i < RD_LAT; i++) tag_q[i] <= tag_q[i-1];
    end
  end

  assign {t_read, t_elem, t_addr, t_exp} = tag_q[RD_LAT-1];
  assign mismatch = t_read && (mem_rdata != t_exp);

  // Register the verdict on the aligned read data; writes carry t_read=0 and never compare.
  always_ff @(posedge clk) begin
    if (rst) begin
      fail_valid <= 1'b0;
      fail_addr  <= '0;
      fail_elem  <= '0;
    end else begin
      fail_valid <= mismatch;
      fail_addr  <= mismatch ? t_addr : '0;
      fail_elem  <= mismatch ? t_elem : '0;
    end
  end

  // Count mismatches, sticking at all-ones instead of wrapping.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      fail_count <= '0;
    end else if (mismatch && (fail_count != {FCW{1'b1}})) begin
      fail_count <= fail_count + 1'b1;
    end
  end

endmodule

// File: rtl/march_c_sequencer.sv
// rtl/march_c_sequencer.sv - March C- MBIST sequencer: FSM and address/op/element counters
module march_c_sequencer
  import mbist_pkg::*;
#(
  parameter int  WCOUNT  = 256,
  parameter int  WLENGTH = 4,
  parameter int  RD_LAT  = 1,
  parameter int  FCW     = 8,
  localparam int AW      = $clog2(WCOUNT)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  output logic [AW-1:0]      mem_addr,
  output logic [WLENGTH-1:0] mem_wdata,
  output logic               mem_we,
  input  logic [WLENGTH-1:0] mem_rdata,
  output logic               busy,
  output logic               done,
  output logic               pass,
  output logic               fail_valid,
  output logic [AW-1:0]      fail_addr,
  output logic [2:0]         fail_elem,
  output logic [FCW-1:0]     fail_count
);

  state_e             state_q, state_d;
  logic [AW-1:0]      addr_q, addr_d;
  logic               op_q, op_d;
  logic [2:0]         elem_q, elem_d, elem_nxt;
  logic [2:0]         drain_q, drain_d;
  logic               pass_q, pass_d;
  logic               cnt_clear;
  logic               rd_issue;
  logic               bg;
  logic               last_op;
  logic               last_addr;
  logic [WLENGTH-1:0] rd_exp;

  // State and counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      addr_q  <= '0;
      op_q    <= 1'b0;
      elem_q  <= '0;
      drain_q <= '0;
      pass_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      op_q    <= op_d;
      elem_q  <= elem_d;
      drain_q <= drain_d;
      pass_q  <= pass_d;
    end
  end

  // Next-state, counter stepping and RAM-side outputs.
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    op_d      = op_q;
    elem_d    = elem_q;
    drain_d   = drain_q;
    pass_d    = pass_q;
    elem_nxt  = elem_q + 3'd1;
    mem_addr  = '0;
    mem_wdata = '0;
    mem_we    = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    pass      = pass_q;
    cnt_clear = 1'b0;
    rd_issue  = 1'b0;
    bg        = 1'b0;
    rd_exp    = '0;
    last_op   = 1'b0;
    last_addr = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d   = RUN;
          cnt_clear = 1'b1;
          pass_d    = 1'b1;
          addr_d    = '0;
          op_d      = 1'b0;
          elem_d    = '0;
        end
      end
      RUN: begin
        busy      = 1'b1;
        bg        = op_data(elem_q, op_q);
        rd_issue  = op_is_read(elem_q, op_q);
        rd_exp    = {WLENGTH{bg}};
        mem_addr  = addr_q;
        mem_wdata = {WLENGTH{bg}};
        mem_we    = !rd_issue;
        last_op   = op_q || !ELEM_TWO_OPS[elem_q];
        last_addr = ELEM_DOWN[elem_q] ? (addr_q == '0) : (addr_q == {AW{1'b1}});
        if (!last_op) begin
          op_d = 1'b1;
        end else begin
          op_d = 1'b0;
          if (!last_addr) begin
            addr_d = ELEM_DOWN[elem_q] ? addr_q - 1'b1 : addr_q + 1'b1;
          end else if (elem_q == 3'(NUM_ELEM - 1)) begin
            state_d = DRAIN;
            drain_d = '0;
            addr_d  = '0;
          end else begin
            // Element boundary reloads the address rather than letting it wrap.
            elem_d = elem_nxt;
            addr_d = ELEM_DOWN[elem_nxt] ? {AW{1'b1}} : '0;
          end
        end
      end
      DRAIN: begin
        busy = 1'b1;
        if (drain_q == 3'(RD_LAT)) state_d = DONE;
        else                       drain_d = drain_q + 3'd1;
      end
      DONE: begin
        done    = 1'b1;
        pass    = (fail_count == '0);
        pass_d  = pass;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  mbist_cmp_pipe #(
    .WLENGTH(WLENGTH),
    .AW     (AW),
    .RD_LAT (RD_LAT),
    .FCW    (FCW)
  ) u_cmp (
    .clk       (clk),
    .rst       (rst),
    .clear     (cnt_clear),
    .issue_read(rd_issue),
    .issue_addr(mem_addr),
    .issue_elem(elem_q),
    .issue_exp (rd_exp),
    .mem_rdata (mem_rdata),
    .fail_valid(fail_valid),
    .fail_addr (fail_addr),
    .fail_elem (fail_elem),
    .fail_count(fail_count)
  );

endmodule
